// File: rtl/defines.sv
// Shared game-wide constants and the collision event encoding.
package defines;

  localparam int LIFE_INIT               = 3;
  localparam int COOLDOWN_FRAMES_DEFAULT = 8;

  typedef enum logic [2:0] {
    EVT_NONE   = 3'd0,
    EVT_BOTTOM = 3'd1,
    EVT_BAD    = 3'd2,
    EVT_GOOD   = 3'd3,
    EVT_BOUNCE = 3'd4
  } evt_kind_t;

  typedef struct packed {
    logic bottom;
    logic bad;
    logic good;
    logic bounce;
  } hits_t;

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } sched_state_t;

  // Priority order: BOTTOM > BAD > GOOD > BOUNCE.
  function automatic evt_kind_t pick_event(input hits_t h);
    if (h.bottom)      return EVT_BOTTOM;
    else if (h.bad)    return EVT_BAD;
    else if (h.good)   return EVT_GOOD;
    else if (h.bounce) return EVT_BOUNCE;
    else               return EVT_NONE;
  endfunction

  // Pending bits retired when an event is accepted; a lost ball retires everything.
  function automatic hits_t accept_clear(input evt_kind_t k);
    hits_t m;
    m = '0;
    case (k)
      EVT_BOTTOM: m = '1;
      EVT_BAD:    m.bad = 1'b1;
      EVT_GOOD:   m.good = 1'b1;
      EVT_BOUNCE: m.bounce = 1'b1;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/collision_cooldown.sv
// Frame-counted cooldown: blocks obstacle captures for COOLDOWN_FRAMES frame starts after a load.
module collision_cooldown #(
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic startOfFrame,
  input  logic flush,
  output logic active
);

  localparam int W = $clog2(COOLDOWN_FRAMES + 2);

  logic [W-1:0] count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush)
      count <= '0;
    else if (load)
      count <= W'(COOLDOWN_FRAMES);
    else if (startOfFrame && count != '0)
      count <= count - W'(1);
  end

  assign active = (count != '0);

endmodule

// File: rtl/collision_scheduler.sv
// Turns per-frame collision flags into one prioritized valid/ready event at a time.
// Optional COLLISION_STATS_EN adds a saturating count of captures dropped by cooldown.
module collision_scheduler
  import defines::*;
#(
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      startOfFrame,
  input  logic      pause,
  input  logic      collisionSmileyBorderBottom,
  input  logic      collisionSmileyBorderSide,
  input  logic      collisionSmileyObstacle,
  input  logic      collisionSmileyObstacleGood,
  input  logic      collisionSmileyObstacleBad,
  input  logic      evt_ready,
  output logic      evt_valid,
  output evt_kind_t evt_kind,
  output logic      cooldown_active
`ifdef COLLISION_STATS_EN
  ,
  output logic [7:0] dropped_count
`endif
);

  hits_t        hits_now, sticky, pending, clr;
  sched_state_t state, state_next;
  evt_kind_t    kind_next;
  logic         load_cooldown;
  logic         bottom_accept;
  logic         good_hit, bad_hit;

  assign good_hit = collisionSmileyObstacle && collisionSmileyObstacleGood;
  assign bad_hit  = collisionSmileyObstacle && collisionSmileyObstacleBad;

  always_comb begin
    hits_now.bottom = collisionSmileyBorderBottom;
    hits_now.bad    = bad_hit && !cooldown_active;
    hits_now.good   = good_hit && !cooldown_active;
    hits_now.bounce = collisionSmileyBorderSide;
  end

  // A collision in the frame-boundary cycle belongs to the next frame.
  always_ff @(posedge clk) begin
    if (reset || pause || bottom_accept)
      sticky <= '0;
    else if (startOfFrame)
      sticky <= hits_now;
    else
      sticky <= sticky | hits_now;
  end

  // Ordering the OR after the clear makes a same-cycle set win.
  always_ff @(posedge clk) begin
    if (reset || pause)
      pending <= '0;
    else
      pending <= (pending & ~clr) | (startOfFrame ? sticky : hits_t'('0));
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next    = state;
    kind_next     = evt_kind;
    clr           = '0;
    load_cooldown = 1'b0;
    bottom_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending != '0) begin
          kind_next  = pick_event(pending);
          state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          clr           = accept_clear(evt_kind);
          load_cooldown = (evt_kind == EVT_GOOD) || (evt_kind == EVT_BAD);
          bottom_accept = (evt_kind == EVT_BOTTOM);
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (pause) begin
      state_next = ST_IDLE;
      kind_next  = EVT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_kind  <= EVT_NONE;
    end else begin
      state     <= state_next;
      evt_valid <= (state_next == ST_OFFER);
      evt_kind  <= kind_next;
    end
  end

  collision_cooldown #(
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_cooldown (
    .clk         (clk),
    .reset       (reset),
    .load        (load_cooldown),
    .startOfFrame(startOfFrame),
    .flush       (pause),
    .active      (cooldown_active)
  );

`ifdef COLLISION_STATS_EN
  // Survives pause so the controller can read totals across a paused game.
  always_ff @(posedge clk) begin
    if (reset)
      dropped_count <= '0;
    else if ((good_hit || bad_hit) && cooldown_active && dropped_count != 8'hFF)
      dropped_count <= dropped_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: directed scenarios plus a randomized run
// against a frame-level reference model.
module tb_collision_scheduler;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset, startOfFrame, pause, bot, side, obs, good, bad, evt_ready;
  logic       evt_valid;
  logic [2:0] evt_kind;
  logic       cooldown_active;
`ifdef COLLISION_STATS_EN
  logic [7:0] dropped_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, indexed by event code: 1=BOTTOM 2=BAD 3=GOOD 4=BOUNCE (lower = higher priority).
  bit [4:1] m_sticky, m_pending;
  bit       m_offer;
  int       m_kind, m_cool, m_drop;

  always #5 clk = ~clk;

  collision_scheduler #(.COOLDOWN_FRAMES(N)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .startOfFrame               (startOfFrame),
    .pause                      (pause),
    .collisionSmileyBorderBottom(bot),
    .collisionSmileyBorderSide  (side),
    .collisionSmileyObstacle    (obs),
    .collisionSmileyObstacleGood(good),
    .collisionSmileyObstacleBad (bad),
    .evt_ready                  (evt_ready),
    .evt_valid                  (evt_valid),
    .evt_kind                   (evt_kind),
    .cooldown_active            (cooldown_active)
`ifdef COLLISION_STATS_EN
    ,
    .dropped_count              (dropped_count)
`endif
  );

  task automatic model_step();
    bit [4:1] hits, old_p, old_s;
    bit       act, acc;
    int       acc_kind;
    act = (m_cool != 0);
    if (reset) begin
      m_sticky = '0; m_pending = '0; m_offer = 0; m_kind = 0; m_cool = 0; m_drop = 0;
      return;
    end
    if (obs && (good || bad) && act && m_drop < 255) m_drop++;
    if (pause) begin
      m_sticky = '0; m_pending = '0; m_offer = 0; m_kind = 0; m_cool = 0;
      return;
    end
    hits     = {side, obs & good & !act, obs & bad & !act, bot};
    old_p    = m_pending;
    old_s    = m_sticky;
    acc      = m_offer && evt_ready;
    acc_kind = m_kind;
    if (acc) begin
      if (acc_kind == 1) m_pending = '0;
      else m_pending[acc_kind] = 1'b0;
    end
    if (startOfFrame) m_pending |= old_s;
    if (acc && acc_kind == 1) m_sticky = '0;
    else if (startOfFrame) m_sticky = hits;
    else m_sticky = old_s | hits;
    if (acc && (acc_kind == 2 || acc_kind == 3)) m_cool = N;
    else if (startOfFrame && m_cool > 0) m_cool--;
    if (m_offer) m_offer = !evt_ready;
    else if (old_p != 0) begin
      m_offer = 1;
      for (int k = 4; k >= 1; k--) if (old_p[k]) m_kind = k;
    end
  endtask

  // Argument order: sof, bottom, side, obstacle, good, bad, ready, pause, reset.
  task automatic tick(input bit s, b, sd, o, g, bd, r, p, rs);
    startOfFrame = s; bot = b; side = sd; obs = o; good = g; bad = bd;
    evt_ready = r; pause = p; reset = rs;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, r, 0, 0);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_checks++; if (evt_kind !== 3'd0) begin n_fail++; $display("FAIL reset_kind: got %0d want 0", evt_kind); end
    n_checks++; if (cooldown_active !== 1'b0) begin n_fail++; $display("FAIL reset_cooldown: got %b want 0", cooldown_active); end
`ifdef COLLISION_STATS_EN
    n_checks++; if (dropped_count !== 8'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
`endif
  endtask

  task automatic test_good_latency();
    tick(0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(2, 1);
    tick(0, 0, 0, 1, 1, 0, 1, 0, 0);
    idle(3, 1);
    tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge_t: got %b want 0", evt_valid); end
    tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (evt_valid !== 1'b1 || evt_kind !== 3'd3) begin n_fail++; $display("FAIL latency_offer: got v=%b k=%0d want v=1 k=3", evt_valid, evt_kind); end
    tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL latency_after_accept: got %b want 0", evt_valid); end
  endtask

  task automatic test_bottom_priority();
    int offers, first_kind;
    tick(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 1, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 1, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
    offers = 0; first_kind = -1;
    for (int i = 0; i < 40; i++) begin
      tick((i % 10) == 9, 0, 0, 0, 0, 0, 1, 0, 0);
      if (evt_valid === 1'b1) begin
        offers++;
        if (first_kind < 0) first_kind = evt_kind;
      end
    end
    n_checks++; if (offers !== 1) begin n_fail++; $display("FAIL bottom_offer_count: got %0d want 1", offers); end
    n_checks++; if (first_kind !== 1) begin n_fail++; $display("FAIL bottom_kind: got %0d want 1", first_kind); end
  endtask

  task automatic test_back_pressure();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (evt_valid !== 1'b1 || evt_kind !== 3'd2) begin n_fail++; $display("FAIL stall_hold_%0d: got v=%b k=%0d want v=1 k=2", i, evt_valid, evt_kind); end
    end
    tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL back_to_back_gap: got %b want 0", evt_valid); end
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (evt_valid !== 1'b1 || evt_kind !== 3'd4) begin n_fail++; $display("FAIL back_to_back_next: got v=%b k=%0d want v=1 k=4", evt_valid, evt_kind); end
  endtask

  task automatic test_cooldown();
    tick(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 1, 1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (cooldown_active !== 1'b1) begin n_fail++; $display("FAIL cooldown_start: got %b want 1", cooldown_active); end
    for (int f = 0; f < N; f++) begin
      tick(0, 0, 0, 1, 1, 0, 1, 0, 0);
      n_checks++; if (cooldown_active !== 1'b1) begin n_fail++; $display("FAIL cooldown_frame_%0d: got %b want 1", f, cooldown_active); end
      idle(2, 1);
      tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(2, 1);
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL cooldown_blocked_%0d: got %b want 0", f, evt_valid); end
    end
    n_checks++; if (cooldown_active !== 1'b0) begin n_fail++; $display("FAIL cooldown_end: got %b want 0", cooldown_active); end
    tick(0, 0, 0, 1, 1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (evt_valid !== 1'b1 || evt_kind !== 3'd3) begin n_fail++; $display("FAIL cooldown_release: got v=%b k=%0d want v=1 k=3", evt_valid, evt_kind); end
`ifdef COLLISION_STATS_EN
    n_checks++; if (dropped_count !== 8'd8) begin n_fail++; $display("FAIL cooldown_dropped: got %0d want 8", dropped_count); end
`endif
  endtask

  task automatic test_pause();
    int late;
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (evt_valid !== 1'b1 || evt_kind !== 3'd4) begin n_fail++; $display("FAIL pause_pre_offer: got v=%b k=%0d want v=1 k=4", evt_valid, evt_kind); end
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL pause_withdraw: got %b want 0", evt_valid); end
    late = 0;
    for (int i = 0; i < 30; i++) begin
      tick((i % 8) == 4, 0, 0, 0, 0, 0, 0, 0, 0);
      if (evt_valid !== 1'b0) late++;
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL pause_no_reissue: got %0d offer cycles want 0", late); end
  endtask

  task automatic test_reset_mid_offer();
    tick(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 1, 1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2, 1);
    tick(0, 0, 1, 1, 0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (evt_valid !== 1'b1 || cooldown_active !== 1'b1) begin n_fail++; $display("FAIL rst_pre_state: got v=%b cd=%b want v=1 cd=1", evt_valid, cooldown_active); end
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (evt_valid !== 1'b0 || evt_kind !== 3'd0 || cooldown_active !== 1'b0) begin n_fail++; $display("FAIL rst_mid_offer: got v=%b k=%0d cd=%b want 0 0 0", evt_valid, evt_kind, cooldown_active); end
`ifdef COLLISION_STATS_EN
    n_checks++; if (dropped_count !== 8'd0) begin n_fail++; $display("FAIL rst_dropped: got %0d want 0", dropped_count); end
`endif
  endtask

  task automatic test_random();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(11) == 0, $urandom_range(29) == 0, $urandom_range(7) == 0,
           $urandom_range(3) == 0, $urandom_range(1) == 0, $urandom_range(1) == 0,
           $urandom_range(2) != 0, $urandom_range(79) == 0, $urandom_range(999) == 0);
      n_checks++; if (evt_valid !== m_offer) begin n_fail++; $display("FAIL rand_valid @%0d: got %b want %b", i, evt_valid, m_offer); end
      if (m_offer) begin
        n_checks++; if (evt_kind !== 3'(m_kind)) begin n_fail++; $display("FAIL rand_kind @%0d: got %0d want %0d", i, evt_kind, m_kind); end
      end
      n_checks++; if (cooldown_active !== (m_cool != 0)) begin n_fail++; $display("FAIL rand_cooldown @%0d: got %b want %b", i, cooldown_active, m_cool != 0); end
`ifdef COLLISION_STATS_EN
      n_checks++; if (dropped_count !== 8'(m_drop)) begin n_fail++; $display("FAIL rand_dropped @%0d: got %0d want %0d", i, dropped_count, m_drop); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; pause = 1'b0; bot = 1'b0; side = 1'b0;
    obs = 1'b0; good = 1'b0; bad = 1'b0; evt_ready = 1'b0;
    test_reset();
    test_good_latency();
    test_bottom_priority();
    test_back_pressure();
    test_cooldown();
    test_pause();
    test_reset_mid_offer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
